ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage of the 16-bit pipelined CPU: a 16-bit ALU plus operand muxing.
//  Decodes instr[15:12] and forms result/rt_out from alu1, alu2 and instr immediates.
//  Registers result, rt_out and flags into the EX/MEM boundary.
//  Sits between decode/register-read and the memory stage.
// PARAMETERS
//  W  16  datapath width; all arithmetic assumes 16.
// PORTS
//  clk       in   1   clock; all state updates on posedge
//  rst       in   1   synchronous, active-high reset
//  stall     in   1   1 = hold every output register unchanged
//  in_valid  in   1   current instr/operands are a real instruction
//  instr     in   16  {op[3:0], f1[3:0], f2[3:0], f3[3:0]}
//  alu1      in   16  operand A (rs; rt for SW/LHB/LLB; SP for CALL/RET)
//  alu2      in   16  operand B (rt; base register for SW/LW)
//  result    out  16  registered ALU result / effective address / new SP
//  rt_out    out  16  registered store data (SW) or return-address data (CALL)
//  out_valid out  1   registered in_valid
//  z, v, n   out  1   registered zero / signed-overflow / negative flags
// BEHAVIOUR
//  Reset (rst=1 at posedge): result=0, rt_out=0, out_valid=0, z=v=n=0. Reset beats stall.
//  Latency 1: values sampled at posedge N appear after posedge N.
//  stall=1, rst=0: all outputs hold. stall=0: load new values; out_valid<=in_valid.
//  in_valid=0: result/rt_out still load computed values; flags hold.
//  Opcodes (op=instr[15:12]); imm4=instr[3:0]; imm8=instr[7:0]:
//   0 ADD  alu1+alu2           1 SUB  alu1-alu2
//   2 NAND ~(alu1&alu2)        3 XOR  alu1^alu2
//   4 INC  alu1+sext(imm4)     5 SRA  alu1>>>imm4 (sign fill)
//   6 SRL  alu1>>imm4 (0 fill) 7 SLL  alu1<<imm4
//   8 SW   alu2+sext(imm8); rt_out=alu1
//   9 LW   alu2+sext(imm8)
//   A LHB  {imm8, alu1[7:0]}   B LLB  {alu1[15:8], imm8}
//   C B    result=alu1 (branch resolved elsewhere)
//   D CALL alu1-1; rt_out=alu1  E RET  alu1+1
//   F HLT  result=0
//  rt_out = alu1 for every op; only SW and CALL consumers use it.
//  Shift amount is always imm4 (0..15); alu2 is ignored for ops 4-7; shift by 0 = pass.
//  All adds wrap mod 2^16 (unless CONFIGURATION macro).
//  Flags update only when in_valid=1, stall=0, op in 0..7:
//   z = (result==0); n = result[15]
//   v = signed overflow for ADD/SUB/INC, else 0
//  Other ops leave flags unchanged.
// CONFIGURATION
//  EX_SAT_EN defined:
//   ADD/SUB/INC saturate on signed overflow (+ overflow -> 16'h7FFF, - overflow -> 16'h8000).
//   v still reports the overflow.
//  EX_SAT_EN undefined: wrap-around, as above. Other ops identical either way.
// TESTING
//  ADD alu1=0001 alu2=0002 -> result=0003, z=0 n=0 v=0 one cycle later.
//  SUB 0002-0001 -> 0001. NAND FFFF,FFFE -> 0001. XOR FFFF,FFF0 -> 000F.
//  INC alu1=00FF imm4=1 -> 0100.
//  Shifts, alu1=80FF imm4=4: SRA -> F80F; SRL -> 080F; SLL -> 0FF0.
//  SW alu1=CAFE alu2=F000 imm8=44 -> result=F044, rt_out=CAFE.
//  LW alu2=BA00 imm8=55 -> BA55.
//  LHB alu1=00EF imm8=BE -> BEEF. LLB alu1=BAAD imm8=BE -> BABE.
//  CALL alu1=1234 -> result=1233, rt_out=1234. RET alu1=1234 -> 1235.
//  ADD 7FFF+0001: wraps -> 8000, v=1 n=1; with EX_SAT_EN -> 7FFF, v=1.
//  rst=1 mid-stream -> all outputs 0 next edge. stall=1 -> outputs frozen across 3 cycles.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: 16-bit ALU, operand muxing and EX/MEM output registers.
// Optional EX_SAT_EN: ADD/SUB/INC saturate on signed overflow instead of wrapping.
module ex_stage #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         in_valid,
    input  logic [15:0]  instr,
    input  logic [W-1:0] alu1,
    input  logic [W-1:0] alu2,
    output logic [W-1:0] result,
    output logic [W-1:0] rt_out,
    output logic         out_valid,
    output logic         z,
    output logic         v,
    output logic         n
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_NAND = 4'h2,
        OP_XOR  = 4'h3,
        OP_INC  = 4'h4,
        OP_SRA  = 4'h5,
        OP_SRL  = 4'h6,
        OP_SLL  = 4'h7,
        OP_SW   = 4'h8,
        OP_LW   = 4'h9,
        OP_LHB  = 4'hA,
        OP_LLB  = 4'hB,
        OP_B    = 4'hC,
        OP_CALL = 4'hD,
        OP_RET  = 4'hE,
        OP_HLT  = 4'hF
    } op_t;

    op_t        op;
    logic [3:0] imm4;
    logic [7:0] imm8;
    logic [15:0] sext4;
    logic [15:0] sext8;

    assign op    = op_t'(instr[15:12]);
    assign imm4  = instr[3:0];
    assign imm8  = instr[7:0];
    assign sext4 = {{12{imm4[3]}}, imm4};
    assign sext8 = {{8{imm8[7]}}, imm8};

    // Shared adder for the arithmetic ops that report overflow; SUB adds ~b + 1.
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_cin;
    logic [15:0] add_sum;
    logic        add_ovf;
    logic        arith_op;

    always_comb begin
        add_a   = alu1;
        add_b   = alu2;
        add_cin = 1'b0;
        case (op)
            OP_SUB: begin
                add_b   = ~alu2;
                add_cin = 1'b1;
            end
            OP_INC:  add_b = sext4;
            default: add_b = alu2;
        endcase
    end

    assign add_sum  = add_a + add_b + {15'd0, add_cin};
    assign add_ovf  = (add_a[15] == add_b[15]) && (add_sum[15] != add_a[15]);
    assign arith_op = (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC);

    logic [15:0] arith_res;

`ifdef EX_SAT_EN
    // On overflow the wrapped sign is inverted, so a negative-looking sum means + overflow.
    always_comb begin
        arith_res = add_sum;
        if (add_ovf)
            arith_res = add_sum[15] ? 16'h7FFF : 16'h8000;
    end
`else
    assign arith_res = add_sum;
`endif

    logic [15:0] sra_res;
    logic [15:0] srl_res;
    logic [15:0] sll_res;
    logic [15:0] mem_addr;

    assign sra_res  = 16'($signed(alu1) >>> imm4);
    assign srl_res  = alu1 >> imm4;
    assign sll_res  = alu1 << imm4;
    assign mem_addr = alu2 + sext8;

    logic [15:0] res_nxt;
    logic        v_nxt;
    logic        flag_upd;

    always_comb begin
        res_nxt = 16'h0000;
        case (op)
            OP_ADD, OP_SUB, OP_INC: res_nxt = arith_res;
            OP_NAND: res_nxt = ~(alu1 & alu2);
            OP_XOR:  res_nxt = alu1 ^ alu2;
            OP_SRA:  res_nxt = sra_res;
            OP_SRL:  res_nxt = srl_res;
            OP_SLL:  res_nxt = sll_res;
            OP_SW, OP_LW: res_nxt = mem_addr;
            OP_LHB:  res_nxt = {imm8, alu1[7:0]};
            OP_LLB:  res_nxt = {alu1[15:8], imm8};
            OP_B:    res_nxt = alu1;
            OP_CALL: res_nxt = alu1 - 16'd1;
            OP_RET:  res_nxt = alu1 + 16'd1;
            OP_HLT:  res_nxt = 16'h0000;
            default: res_nxt = 16'h0000;
        endcase
    end

    assign v_nxt    = arith_op && add_ovf;
    assign flag_upd = in_valid && !instr[15];

    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= '0;
            rt_out    <= '0;
            out_valid <= 1'b0;
            z         <= 1'b0;
            v         <= 1'b0;
            n         <= 1'b0;
        end else if (!stall) begin
            result    <= res_nxt;
            rt_out    <= alu1;
            out_valid <= in_valid;
            if (flag_upd) begin
                z <= (res_nxt == 16'h0000);
                n <= res_nxt[15];
                v <= v_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed vectors with hand-computed results,
// expected outputs queued per clock and checked by an independent monitor.
module tb_ex_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        in_valid;
    logic [15:0] instr;
    logic [15:0] alu1;
    logic [15:0] alu2;
    logic [15:0] result;
    logic [15:0] rt_out;
    logic        out_valid;
    logic        z;
    logic        v;
    logic        n;

    ex_stage dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .in_valid  (in_valid),
        .instr     (instr),
        .alu1      (alu1),
        .alu2      (alu2),
        .result    (result),
        .rt_out    (rt_out),
        .out_valid (out_valid),
        .z         (z),
        .v         (v),
        .n         (n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] res;
        logic [15:0] rt;
        logic        vld;
        logic        z;
        logic        v;
        logic        n;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference register state, advanced once per clock by the driver.
    logic [15:0] m_res = 16'h0;
    logic [15:0] m_rt  = 16'h0;
    logic        m_vld = 1'b0;
    logic        m_z   = 1'b0;
    logic        m_v   = 1'b0;
    logic        m_n   = 1'b0;

    task automatic issue(input string nm, input logic [15:0] ins, input logic [15:0] a,
                         input logic [15:0] b, input logic vld, input logic stl,
                         input logic rs, input logic [15:0] exp_res, input logic exp_v);
        exp_t e;
        @(negedge clk);
        instr    = ins;
        alu1     = a;
        alu2     = b;
        in_valid = vld;
        stall    = stl;
        rst      = rs;
        @(posedge clk);
        if (rs) begin
            m_res = 16'h0; m_rt = 16'h0; m_vld = 1'b0;
            m_z = 1'b0; m_v = 1'b0; m_n = 1'b0;
        end else if (!stl) begin
            m_res = exp_res;
            m_rt  = a;
            m_vld = vld;
            if (vld && !ins[15]) begin
                m_z = (exp_res == 16'h0);
                m_n = exp_res[15];
                m_v = exp_v;
            end
        end
        e.name = nm; e.res = m_res; e.rt = m_rt; e.vld = m_vld;
        e.z = m_z; e.v = m_v; e.n = m_n;
        exp_q.push_back(e);
    endtask

    task automatic cmp(input string nm, input string fld, input logic [15:0] act,
                       input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, req);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp(e.name, "result", result, e.res);
            cmp(e.name, "rt_out", rt_out, e.rt);
            cmp(e.name, "out_valid", {15'd0, out_valid}, {15'd0, e.vld});
            cmp(e.name, "z", {15'd0, z}, {15'd0, e.z});
            cmp(e.name, "v", {15'd0, v}, {15'd0, e.v});
            cmp(e.name, "n", {15'd0, n}, {15'd0, e.n});
        end
    end

    initial begin
        rst = 1'b1; stall = 1'b0; in_valid = 1'b0;
        instr = 16'h0; alu1 = 16'h0; alu2 = 16'h0;

        issue("reset",     16'h0000, 16'h1111, 16'h2222, 1, 0, 1, 16'h0000, 0);
        issue("add",       16'h0000, 16'h0001, 16'h0002, 1, 0, 0, 16'h0003, 0);
        issue("sub",       16'h1000, 16'h0002, 16'h0001, 1, 0, 0, 16'h0001, 0);
        issue("nand",      16'h2000, 16'hFFFF, 16'hFFFE, 1, 0, 0, 16'h0001, 0);
        issue("xor",       16'h3000, 16'hFFFF, 16'hFFF0, 1, 0, 0, 16'h000F, 0);
        issue("inc",       16'h4001, 16'h00FF, 16'h9999, 1, 0, 0, 16'h0100, 0);
        issue("inc_neg",   16'h400F, 16'h0000, 16'h0000, 1, 0, 0, 16'hFFFF, 0);
        issue("sra",       16'h5004, 16'h80FF, 16'h0000, 1, 0, 0, 16'hF80F, 0);
        issue("srl",       16'h6004, 16'h80FF, 16'h0000, 1, 0, 0, 16'h080F, 0);
        issue("sll",       16'h7004, 16'h80FF, 16'h0000, 1, 0, 0, 16'h0FF0, 0);
        issue("sra0",      16'h5000, 16'h8001, 16'h0003, 1, 0, 0, 16'h8001, 0);
        issue("sll15",     16'h700F, 16'h0003, 16'h0000, 1, 0, 0, 16'h8000, 0);
        issue("sw",        16'h8044, 16'hCAFE, 16'hF000, 1, 0, 0, 16'hF044, 0);
        issue("lw",        16'h9055, 16'h0000, 16'hBA00, 1, 0, 0, 16'hBA55, 0);
        issue("lw_neg",    16'h90FF, 16'h0000, 16'h0010, 1, 0, 0, 16'h000F, 0);
        issue("lhb",       16'hA0BE, 16'h00EF, 16'h0000, 1, 0, 0, 16'hBEEF, 0);
        issue("llb",       16'hB0BE, 16'hBAAD, 16'h0000, 1, 0, 0, 16'hBABE, 0);
        issue("br",        16'hC000, 16'h1357, 16'h0000, 1, 0, 0, 16'h1357, 0);
        issue("call",      16'hD000, 16'h1234, 16'h0000, 1, 0, 0, 16'h1233, 0);
        issue("ret",       16'hE000, 16'h1234, 16'h0000, 1, 0, 0, 16'h1235, 0);
        issue("hlt",       16'hF000, 16'h5555, 16'h0000, 1, 0, 0, 16'h0000, 0);
`ifdef EX_SAT_EN
        issue("add_ovf",   16'h0000, 16'h7FFF, 16'h0001, 1, 0, 0, 16'h7FFF, 1);
        issue("sub_ovf",   16'h1000, 16'h8000, 16'h0001, 1, 0, 0, 16'h8000, 1);
`else
        issue("add_ovf",   16'h0000, 16'h7FFF, 16'h0001, 1, 0, 0, 16'h8000, 1);
        issue("sub_ovf",   16'h1000, 16'h8000, 16'h0001, 1, 0, 0, 16'h7FFF, 1);
`endif
        issue("add_zero",  16'h0000, 16'hFFFF, 16'h0001, 1, 0, 0, 16'h0000, 0);
        issue("invalid",   16'h0000, 16'h0001, 16'h0001, 0, 0, 0, 16'h0002, 0);
        issue("xor_neg",   16'h3000, 16'h8000, 16'h0001, 1, 0, 0, 16'h8001, 0);
        issue("stall1",    16'h0000, 16'h0005, 16'h0005, 1, 1, 0, 16'h000A, 0);
        issue("stall2",    16'h1000, 16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 0);
        issue("stall3",    16'hD000, 16'h4444, 16'h0000, 0, 1, 0, 16'h4443, 0);
        issue("post_stall",16'h0000, 16'h0005, 16'h0005, 1, 0, 0, 16'h000A, 0);
        issue("sw_mid",    16'h8001, 16'hBEEF, 16'h1000, 1, 0, 0, 16'h1001, 0);
        issue("rst_stall", 16'h0000, 16'h7FFF, 16'h0001, 1, 1, 1, 16'h0000, 0);
        issue("after_rst", 16'h1000, 16'h0000, 16'h0001, 1, 0, 0, 16'hFFFF, 0);

        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
